hflip_stage: RTL and testbench

Random horizontal-flip augmentation stage sitting directly downstream of the blur/skip-blur stage in the augmentation pipeline. Accepts a 28×28 pixel stream (one pixel per valid cycle, raster order, no backpressure), buffers one row at a time in ping-pong row banks, and re-emits each row either unchanged or column-reversed. The flip decision is made once per image, from a mode input and an internal LFSR, and is held for all rows of that image.

---
 rtl/aug_pkg.sv | 33 +++
 rtl/row_pingpong_buf.sv | 41 ++++
 rtl/hflip_stage.sv | 215 +++++++++++++++++++++
 tb/tb_hflip_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/aug_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aug_pkg                                                                    |
// | Shared types and constants for the image augmentation pipeline stages.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package aug_pkg;

  typedef enum logic [1:0] {
    FLIP_NEVER  = 2'd0,
    FLIP_ALWAYS = 2'd1,
    FLIP_RANDOM = 2'd2
  } flip_mode_t;

  typedef enum logic [0:0] {
    DRAIN_IDLE   = 1'b0,
    DRAIN_ACTIVE = 1'b1
  } drain_state_t;

  localparam int c_img_w      = 28;
  localparam int c_img_h      = 28;
  localparam int c_num_pixels = c_img_w * c_img_h;

  // Taps for x^16 + x^14 + x^13 + x^11 + 1 on a left-shifting Fibonacci LFSR.
  localparam logic [15:0] c_lfsr_taps = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & c_lfsr_taps)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/row_pingpong_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | row_pingpong_buf                                                           |
// | Two row-sized register banks: one write port, one combinational read port. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module row_pingpong_buf #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_W       = 28,
  parameter int ADDR_W      = $clog2(IMG_W)
) (
  input  logic                   clk,
  input  logic                   i_wr_en,
  input  logic                   i_wr_bank,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic [PIXEL_WIDTH-1:0] i_wr_data,
  input  logic                   i_rd_bank,
  input  logic [ADDR_W-1:0]      i_rd_addr,
  output logic [PIXEL_WIDTH-1:0] o_rd_data
);

  logic [PIXEL_WIDTH-1:0] w_bank_data [2];

  // Contents need no reset: a bank is only read after a full row was written.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [PIXEL_WIDTH-1:0] r_row [IMG_W];

    always_ff @(posedge clk) begin
      if (i_wr_en && (i_wr_bank == 1'(b))) begin
        r_row[i_wr_addr] <= i_wr_data;
      end
    end

    assign w_bank_data[b] = r_row[i_rd_addr];
  end

  assign o_rd_data = w_bank_data[i_rd_bank];

endmodule

`default_nettype wire

// File: rtl/hflip_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hflip_stage                                                                |
// | Per-image random horizontal flip of a raster pixel stream via row buffers. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hflip_stage
  import aug_pkg::*;
#(
  parameter int          PIXEL_WIDTH = 8,
  parameter int          IMG_W       = c_img_w,
  parameter int          IMG_H       = c_img_h,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             flip_mode,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic                   pixel_in_valid,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   pixel_out_valid,
  output logic                   image_done,
  output logic                   flip_active
);

  localparam int                 c_col_w    = $clog2(IMG_W);
  localparam int                 c_row_w    = $clog2(IMG_H);
  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_W - 1);
  localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_H - 1);

  logic [c_col_w-1:0]     r_wr_col;
  logic [c_row_w-1:0]     r_wr_row;
  logic                   r_wr_bank;
  logic                   r_img_flip;
  logic [15:0]            r_lfsr;

  drain_state_t           r_state;
  drain_state_t           w_state_nxt;
  logic [c_col_w-1:0]     r_rd_idx;
  logic [c_col_w-1:0]     w_rd_idx_nxt;
  logic                   r_rd_bank;
  logic                   w_rd_bank_nxt;
  logic                   r_rd_flip;
  logic                   w_rd_flip_nxt;
  logic                   r_pend;
  logic                   w_pend_nxt;
  logic                   r_pend_bank;
  logic                   w_pend_bank_nxt;
  logic                   r_pend_flip;
  logic                   w_pend_flip_nxt;
  logic [c_row_w-1:0]     r_out_row;

  logic                   w_img_start;
  logic                   w_req;
  logic                   w_mode_flip;
  logic                   w_cur_flip;
  logic                   w_start;
  logic                   w_emit;
  logic                   w_rd_last;
  logic [c_col_w-1:0]     w_rd_addr;
  logic [PIXEL_WIDTH-1:0] w_rd_data;

  assign w_img_start = pixel_in_valid && (r_wr_col == '0) && (r_wr_row == '0);
  assign w_req       = pixel_in_valid && (r_wr_col == c_col_last);
  assign w_cur_flip  = w_img_start ? w_mode_flip : r_img_flip;
  assign w_emit      = (r_state == DRAIN_ACTIVE);
  assign w_rd_last   = w_emit && (r_rd_idx == c_col_last);
  assign w_rd_addr   = r_rd_flip ? (c_col_last - r_rd_idx) : r_rd_idx;

  always_comb begin
    w_mode_flip = 1'b0;
    case (flip_mode)
      FLIP_NEVER:  w_mode_flip = 1'b0;
      FLIP_ALWAYS: w_mode_flip = 1'b1;
      FLIP_RANDOM: w_mode_flip = r_lfsr[0];
      default:     w_mode_flip = 1'b0;
    endcase
  end

  row_pingpong_buf #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .IMG_W       (IMG_W),
    .ADDR_W      (c_col_w)
  ) u_row_buf (
    .clk       (clk),
    .i_wr_en   (pixel_in_valid),
    .i_wr_bank (r_wr_bank),
    .i_wr_addr (r_wr_col),
    .i_wr_data (pixel_in),
    .i_rd_bank (r_rd_bank),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_col   <= '0;
      r_wr_row   <= '0;
      r_wr_bank  <= 1'b0;
      r_img_flip <= 1'b0;
      r_lfsr     <= LFSR_SEED;
    end else begin
      // A bank must never be handed to the drain while it is still being read.
      assert (!(w_req && w_emit && (r_rd_bank == r_wr_bank)));
      if (pixel_in_valid) begin
        if (w_img_start) begin
          r_img_flip <= w_mode_flip;
          r_lfsr     <= lfsr_step(r_lfsr);
        end
        if (r_wr_col == c_col_last) begin
          r_wr_col  <= '0;
          r_wr_bank <= ~r_wr_bank;
          r_wr_row  <= (r_wr_row == c_row_last) ? '0 : r_wr_row + 1'b1;
        end else begin
          r_wr_col <= r_wr_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= DRAIN_IDLE;
      r_rd_idx    <= '0;
      r_rd_bank   <= 1'b0;
      r_rd_flip   <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_bank <= 1'b0;
      r_pend_flip <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd_idx    <= w_rd_idx_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_rd_flip   <= w_rd_flip_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_bank <= w_pend_bank_nxt;
      r_pend_flip <= w_pend_flip_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rd_idx_nxt    = r_rd_idx;
    w_rd_bank_nxt   = r_rd_bank;
    w_rd_flip_nxt   = r_rd_flip;
    w_pend_nxt      = r_pend;
    w_pend_bank_nxt = r_pend_bank;
    w_pend_flip_nxt = r_pend_flip;
    w_start         = 1'b0;

    case (r_state)
      DRAIN_IDLE:   w_start = r_pend || w_req;
      DRAIN_ACTIVE: begin
        if (r_rd_idx == c_col_last) begin
          w_start = r_pend || w_req;
        end else begin
          w_rd_idx_nxt = r_rd_idx + 1'b1;
        end
      end
      default:      w_start = 1'b0;
    endcase

    if (w_start) begin
      w_state_nxt  = DRAIN_ACTIVE;
      w_rd_idx_nxt = '0;
      if (r_pend) begin
        w_rd_bank_nxt   = r_pend_bank;
        w_rd_flip_nxt   = r_pend_flip;
        w_pend_nxt      = w_req;
        w_pend_bank_nxt = r_wr_bank;
        w_pend_flip_nxt = w_cur_flip;
      end else begin
        w_rd_bank_nxt = r_wr_bank;
        w_rd_flip_nxt = w_cur_flip;
      end
    end else if (w_rd_last) begin
      w_state_nxt = DRAIN_IDLE;
    end else if (w_req) begin
      // Row completed mid-drain: hold it until the current row finishes.
      w_pend_nxt      = 1'b1;
      w_pend_bank_nxt = r_wr_bank;
      w_pend_flip_nxt = w_cur_flip;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
      image_done      <= 1'b0;
      flip_active     <= 1'b0;
      r_out_row       <= '0;
    end else begin
      pixel_out_valid <= w_emit;
      image_done      <= 1'b0;
      if (w_emit) begin
        pixel_out <= w_rd_data;
        if ((r_rd_idx == '0) && (r_out_row == '0)) begin
          flip_active <= r_rd_flip;
        end
        if (r_rd_idx == c_col_last) begin
          if (r_out_row == c_row_last) begin
            r_out_row  <= '0;
            image_done <= 1'b1;
          end else begin
            r_out_row <= r_out_row + 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hflip_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hflip_stage                                                             |
// | Directed self-checking bench for hflip_stage with a cycle-level row model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hflip_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] flip_mode;
  logic [7:0] pixel_in;
  logic       pixel_in_valid;
  logic [7:0] pixel_out;
  logic       pixel_out_valid;
  logic       image_done;
  logic       flip_active;

  always #5 clk = ~clk;

  hflip_stage dut (
    .clk             (clk),
    .reset           (reset),
    .flip_mode       (flip_mode),
    .pixel_in        (pixel_in),
    .pixel_in_valid  (pixel_in_valid),
    .pixel_out       (pixel_out),
    .pixel_out_valid (pixel_out_valid),
    .image_done      (image_done),
    .flip_active     (flip_active)
  );

  typedef struct packed {
    logic [223:0] data;
    logic         flip;
    logic [4:0]   row;
  } row_t;

  row_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;

  logic [15:0]  m_lfsr;
  int           m_col;
  int           m_row;
  logic         m_flip;
  logic [223:0] m_buf;
  bit           m_active;
  int           m_idx;
  row_t         m_cur;
  logic         m_exp_flip;
  logic         m_out_valid;
  logic [7:0]   m_out_pix;
  logic         m_out_done;

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_lfsr      = 16'hACE1;
    m_col       = 0;
    m_row       = 0;
    m_flip      = 1'b0;
    m_buf       = '0;
    m_active    = 1'b0;
    m_idx       = 0;
    m_exp_flip  = 1'b0;
    m_out_valid = 1'b0;
    m_out_pix   = 8'h00;
    m_out_done  = 1'b0;
  endtask

  // One clock: drive inputs, advance the model across the edge, then check.
  task automatic step(input logic v, input logic [7:0] px);
    row_t r;
    pixel_in_valid = v;
    pixel_in       = px;
    @(posedge clk);
    m_out_valid = m_active;
    m_out_done  = 1'b0;
    if (m_active) begin
      m_out_pix = m_cur.data[(m_cur.flip ? 27 - m_idx : m_idx) * 8 +: 8];
      if (m_idx == 0 && m_cur.row == 5'd0) m_exp_flip = m_cur.flip;
      m_out_done = (m_idx == 27) && (m_cur.row == 5'd27);
      m_idx++;
      if (m_idx == 28) m_active = 1'b0;
    end
    if (v) begin
      if (m_col == 0 && m_row == 0) begin
        m_flip = (flip_mode == 2'd1) || ((flip_mode == 2'd2) && m_lfsr[0]);
        m_lfsr = ref_lfsr(m_lfsr);
      end
      m_buf[m_col * 8 +: 8] = px;
      if (m_col == 27) begin
        r.data = m_buf;
        r.flip = m_flip;
        r.row  = 5'(m_row);
        q.push_back(r);
        m_col = 0;
        m_row = (m_row == 27) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    if (!m_active && q.size() > 0) begin
      m_cur    = q.pop_front();
      m_active = 1'b1;
      m_idx    = 0;
    end
    #1;
    check("valid", 32'(pixel_out_valid), 32'(m_out_valid));
    if (m_out_valid) check("pixel", 32'(pixel_out), 32'(m_out_pix));
    check("image_done", 32'(image_done), 32'(m_out_done));
    check("flip_active", 32'(flip_active), 32'(m_exp_flip));
  endtask

  task automatic run_image(input logic [1:0] mode, input logic [1:0] mode_late,
                           input int switch_at, input int n_pix, input bit gaps);
    flip_mode = mode;
    for (int i = 0; i < n_pix; i++) begin
      if (i == switch_at) flip_mode = mode_late;
      if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, 8'($urandom));
      step(1'b1, 8'(i));
    end
  endtask

  task automatic flush();
    repeat (40) step(1'b0, 8'($urandom));
  endtask

  initial begin
    reset          = 1'b1;
    flip_mode      = 2'd0;
    pixel_in       = 8'h00;
    pixel_in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pixel_out", 32'(pixel_out), 32'h0);
    check("rst_valid", 32'(pixel_out_valid), 32'h0);
    check("rst_image_done", 32'(image_done), 32'h0);
    check("rst_flip_active", 32'(flip_active), 32'h0);
    reset = 1'b0;

    // Pass-through, then always-flip.
    run_image(2'd0, 2'd0, -1, 784, 1'b0);
    flush();
    run_image(2'd1, 2'd1, -1, 784, 1'b0);
    flush();

    // Random mode over eight back-to-back images.
    for (int k = 0; k < 8; k++) run_image(2'd2, 2'd2, -1, 784, 1'b0);
    flush();

    // Input gaps with always-flip.
    run_image(2'd1, 2'd1, -1, 784, 1'b1);
    flush();

    // Mode change mid-image only affects the following image.
    run_image(2'd0, 2'd1, 400, 784, 1'b0);
    run_image(2'd1, 2'd1, -1, 784, 1'b0);
    flush();

    // Reset in the middle of an image while a row is draining.
    run_image(2'd1, 2'd1, -1, 300, 1'b0);
    check("pre_rst_draining", 32'(pixel_out_valid), 32'h1);
    reset          = 1'b1;
    pixel_in_valid = 1'b0;
    #1;
    check("mid_rst_valid", 32'(pixel_out_valid), 32'h0);
    check("mid_rst_pixel_out", 32'(pixel_out), 32'h0);
    check("mid_rst_image_done", 32'(image_done), 32'h0);
    check("mid_rst_flip_active", 32'(flip_active), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // LFSR restarts from the seed: random flips 1,1,1,1,0.
    for (int k = 0; k < 5; k++) run_image(2'd2, 2'd2, -1, 784, 1'b0);
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
